// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives program memory, and registers
// the returned word into IF/ID with branch/stall/flush/halt handling.
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  logic [15:0] r_pc;
  logic [15:0] r_if_instr;
  logic [15:0] r_if_pc;
  logic [15:0] r_if_pc_plus2;
  logic        r_if_valid;
  logic        r_halted;
  logic [15:0] r_fetch_count;

  logic [15:0] w_pc_plus2;
  logic        w_is_halt;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_is_halt  = (imem_data == HALT_INSTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= RESET_PC;
      r_if_pc_plus2 <= RESET_PC + 16'd2;
      r_if_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 16'h0000;
    end else if (r_halted) begin
      // Halt word stays in IF/ID but is only issued valid once.
      r_if_valid <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= {branch_target[15:1], 1'b0};
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (stall) begin
      r_pc <= r_pc;
    end else if (flush) begin
      r_pc       <= w_pc_plus2;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else begin
      r_if_instr    <= imem_data;
      r_if_pc       <= r_pc;
      r_if_pc_plus2 <= w_pc_plus2;
      r_if_valid    <= 1'b1;
      r_fetch_count <= (r_fetch_count == 16'hFFFF) ? r_fetch_count
                                                   : r_fetch_count + 16'd1;
      if (w_is_halt) r_halted <= 1'b1;
      else           r_pc     <= w_pc_plus2;
    end
  end

  assign imem_addr   = r_pc;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus2 = r_if_pc_plus2;
  assign if_valid    = r_if_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a byte memory model feeds the DUT and a
// queue of expected IF/ID snapshots is checked after each clock edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_data, imem_addr, if_instr, if_pc, if_pc_plus2, fetch_count;
  logic        if_valid, halted;

  logic [7:0]  mem [0:65535];
  logic [15:0] w_a1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        valid;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  assign w_a1      = imem_addr + 16'd1;
  assign imem_data = {mem[w_a1], mem[imem_addr]};

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_data(imem_data), .imem_addr(imem_addr), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .if_valid(if_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] i, input logic [15:0] p,
                      input logic [15:0] p2, input logic v, input logic h,
                      input logic [15:0] c);
    exp_t e;
    e = '{addr: a, instr: i, pc: p, pc2: p2, valid: v, hlt: h, cnt: c};
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, ".addr"},  imem_addr, e.addr);
    chk({tag, ".instr"}, if_instr, e.instr);
    chk({tag, ".pc"},    if_pc, e.pc);
    chk({tag, ".pc2"},   if_pc_plus2, e.pc2);
    chk({tag, ".valid"}, {15'd0, if_valid}, {15'd0, e.valid});
    chk({tag, ".halt"},  {15'd0, halted}, {15'd0, e.hlt});
    chk({tag, ".cnt"},   fetch_count, e.cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [15:0] t);
    stall = s; flush = f; branch_taken = b; branch_target = t;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
    mem[16'h0006] = 8'h11; mem[16'h0007] = 8'h22;
    mem[16'h000A] = 8'hFF; mem[16'h000B] = 8'hFF;
    mem[16'h0040] = 8'hCD; mem[16'h0041] = 8'hAB;
    mem[16'hFFFE] = 8'hEF; mem[16'hFFFF] = 8'hBE;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    #12;
    push(16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000);
    check("reset");
    rst = 1'b0;

    // Sequential fetch
    push(16'h0002, 16'h1234, 16'h0000, 16'h0002, 1'b1, 1'b0, 16'h0001);
    cyc(); check("fetch0");
    push(16'h0004, 16'h5678, 16'h0002, 16'h0004, 1'b1, 1'b0, 16'h0002);
    cyc(); check("fetch1");

    // Branch with odd target: bit 0 dropped, bubble issued
    drive(1'b0, 1'b0, 1'b1, 16'h0041);
    push(16'h0040, 16'h0000, 16'h0002, 16'h0004, 1'b0, 1'b0, 16'h0002);
    cyc(); check("branch");
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    push(16'h0042, 16'hABCD, 16'h0040, 16'h0042, 1'b1, 1'b0, 16'h0003);
    cyc(); check("after_branch");

    // Branch over stall+flush to reach 0006
    drive(1'b1, 1'b1, 1'b1, 16'h0006);
    push(16'h0006, 16'h0000, 16'h0040, 16'h0042, 1'b0, 1'b0, 16'h0003);
    cyc(); check("branch_prio");

    // Stall three cycles; last also has flush, stall must win
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, (k == 2), 1'b0, 16'h0000);
      push(16'h0006, 16'h0000, 16'h0040, 16'h0042, 1'b0, 1'b0, 16'h0003);
      cyc(); check($sformatf("stall%0d", k));
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    push(16'h0008, 16'h2211, 16'h0006, 16'h0008, 1'b1, 1'b0, 16'h0004);
    cyc(); check("resume");

    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    push(16'h000A, 16'h0000, 16'h0006, 16'h0008, 1'b0, 1'b0, 16'h0004);
    cyc(); check("flush");

    // Halt word at 000A
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    push(16'h000A, 16'hFFFF, 16'h000A, 16'h000C, 1'b1, 1'b1, 16'h0005);
    cyc(); check("halt");
    push(16'h000A, 16'hFFFF, 16'h000A, 16'h000C, 1'b0, 1'b1, 16'h0005);
    cyc(); check("halted_hold");
    drive(1'b1, 1'b1, 1'b1, 16'h0040);
    push(16'h000A, 16'hFFFF, 16'h000A, 16'h000C, 1'b0, 1'b1, 16'h0005);
    cyc(); check("halted_ignore");
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    push(16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000);
    check("async_rst_halt");
    #1 rst = 1'b0;
    mem[16'h000A] = 8'h00; mem[16'h000B] = 8'h00;

    // PC wrap at FFFE
    drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
    push(16'hFFFE, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000);
    cyc(); check("branch_fffe");
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    push(16'h0000, 16'hBEEF, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'h0001);
    cyc(); check("wrap");
    #2 rst = 1'b1;
    #1;
    push(16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0000);
    check("async_rst_run");
    #1 rst = 1'b0;

    // Counter saturation over more than 64K fetches
    repeat (65534) cyc();
    chk("cnt_fffe", fetch_count, 16'hFFFE);
    cyc();
    chk("cnt_ffff", fetch_count, 16'hFFFF);
    repeat (4) cyc();
    chk("cnt_sat", fetch_count, 16'hFFFF);
    chk("sat_valid", {15'd0, if_valid}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
